// File: rtl/uart_byte_tx_if.sv
// Handshake and serial-line bundle between the output-register control logic
// and the byte transmitter.
interface uart_byte_tx_if #(
  parameter int N = 8
);
  logic         load;
  logic [N-1:0] data_in;
  logic         tx;
  logic         busy;
  logic         done;

  // Controller side: requests frames and watches the line status.
  modport master (
    output load,
    output data_in,
    input  tx,
    input  busy,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  load,
    input  data_in,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_byte_tx.sv
// Asynchronous serial transmitter: start bit, N data bits LSB first, one stop
// bit, each held CLKS_PER_BIT clocks. All outputs come straight from flops.
module uart_byte_tx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_byte_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud, baud_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [N-1:0]     shreg, shreg_next;
  logic             tx_q, tx_next;
  logic             busy_q, busy_next;
  logic             done_q, done_next;

  logic bit_end;
  logic last_bit;

  assign bit_end  = (baud == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit = (idx == IDX_W'(N - 1));

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      baud   <= '0;
      idx    <= '0;
      shreg  <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      baud   <= baud_next;
      idx    <= idx_next;
      shreg  <= shreg_next;
      tx_q   <= tx_next;
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  // Next-state selection; a load on the last stop-bit edge chains the next
  // frame with no idle gap, which is how a held load streams frames.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.load) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && last_bit) state_next = STOP;
      STOP:    if (bit_end) state_next = bus.load ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the counters, shift register and registered outputs.
  always_comb begin
    baud_next  = baud;
    idx_next   = idx;
    shreg_next = shreg;
    tx_next    = tx_q;
    busy_next  = busy_q;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (bus.load) begin
          shreg_next = bus.data_in;
          baud_next  = '0;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          baud_next = '0;
          idx_next  = '0;
          tx_next   = shreg[0];
        end else begin
          baud_next = baud + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (last_bit) begin
            tx_next = 1'b1;
          end else begin
            shreg_next = shreg >> 1;
            idx_next   = idx + IDX_W'(1);
            tx_next    = shreg_next[0];
          end
        end else begin
          baud_next = baud + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          done_next = 1'b1;
          if (bus.load) begin
            shreg_next = bus.data_in;
            tx_next    = 1'b0;
            busy_next  = 1'b1;
          end else begin
            tx_next   = 1'b1;
            busy_next = 1'b0;
          end
        end else begin
          baud_next = baud + CNT_W'(1);
        end
      end
      default: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: one instance at 4 clocks/bit, one at 2.
module tb_uart_byte_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_v = 1'b0;
  logic [7:0] data_v = 8'h00;
  logic       sel = 1'b0;   // 0: 4 clocks/bit instance, 1: 2 clocks/bit instance

  int n_checks = 0;
  int n_pass   = 0;

  uart_byte_tx_if #(.N(8)) bus4 ();
  uart_byte_tx_if #(.N(8)) bus2 ();

  assign bus4.load    = load_v & ~sel;
  assign bus2.load    = load_v & sel;
  assign bus4.data_in = data_v;
  assign bus2.data_in = data_v;

  uart_byte_tx #(.N(8), .CLKS_PER_BIT(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  uart_byte_tx #(.N(8), .CLKS_PER_BIT(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  logic obs_tx, obs_busy, obs_done;
  assign obs_tx   = sel ? bus2.tx   : bus4.tx;
  assign obs_busy = sel ? bus2.busy : bus4.busy;
  assign obs_done = sel ? bus2.done : bus4.done;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pulse load for one edge with the given word.
  task automatic start(input logic [7:0] d);
    @(negedge clk);
    load_v = 1'b1;
    data_v = d;
    @(posedge clk);
    #1 load_v = 1'b0;
  endtask

  // Called just after the load edge; checks every cycle of one frame.
  // pat bit i is the expected line level during bit cell i.
  task automatic watch(input string tag, input logic [9:0] pat, input logic first_done);
    int cpb;
    cpb = sel ? 2 : 4;
    for (int k = 0; k < 10 * cpb; k++) begin
      @(negedge clk);
      check($sformatf("%s_tx[%0d]", tag, k), 32'(obs_tx), 32'(pat[k / cpb]));
      check($sformatf("%s_busy[%0d]", tag, k), 32'(obs_busy), 32'd1);
      check($sformatf("%s_done[%0d]", tag, k), 32'(obs_done), (k == 0) ? 32'(first_done) : 32'd0);
    end
  endtask

  // Cycle after the last stop-bit edge, then one idle cycle.
  task automatic post(input string tag);
    @(negedge clk);
    check({tag, "_end_busy"}, 32'(obs_busy), 32'd0);
    check({tag, "_end_done"}, 32'(obs_done), 32'd1);
    check({tag, "_end_tx"},   32'(obs_tx),   32'd1);
    @(negedge clk);
    check({tag, "_idle_done"}, 32'(obs_done), 32'd0);
    check({tag, "_idle_busy"}, 32'(obs_busy), 32'd0);
    check({tag, "_idle_tx"},   32'(obs_tx),   32'd1);
  endtask

  initial begin
    // Asynchronous reset between edges must act before the next posedge.
    #12 reset = 1'b1;
    #1;
    check("rst_async_tx",   32'(bus4.tx),   32'd1);
    check("rst_async_busy", 32'(bus4.busy), 32'd0);
    check("rst_async_done", 32'(bus4.done), 32'd0);
    check("rst_async_tx2",  32'(bus2.tx),   32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_rel_tx",   32'(obs_tx),   32'd1);
      check("rst_rel_busy", 32'(obs_busy), 32'd0);
      check("rst_rel_done", 32'(obs_done), 32'd0);
    end

    // 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    start(8'hA5);
    watch("a5", 10'b1101001010, 1'b0);
    post("a5");

    // 0x3C with a 0xFF load attempt mid-frame that must be ignored.
    start(8'h3C);
    fork
      watch("ign", 10'b1001111000, 1'b0);
      begin
        repeat (9) @(posedge clk);
        #1 load_v = 1'b1; data_v = 8'hFF;
        @(posedge clk);
        #1 load_v = 1'b0;
      end
    join
    post("ign");

    // Load held high: 0x01 then 0x80 back to back, no gap between frames.
    @(negedge clk);
    load_v = 1'b1;
    data_v = 8'h01;
    @(posedge clk);
    fork
      watch("b2b1", 10'b1000000010, 1'b0);
      begin
        @(negedge clk) data_v = 8'h80;
      end
    join
    fork
      watch("b2b2", 10'b1100000000, 1'b1);
      begin
        @(negedge clk) load_v = 1'b0;
      end
    join
    post("b2b2");

    // Mid-frame reset on a 0x00 frame, then a clean 0xFF frame.
    start(8'h00);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      check($sformatf("mid_tx[%0d]", k),   32'(obs_tx),   32'd0);
      check($sformatf("mid_busy[%0d]", k), 32'(obs_busy), 32'd1);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tx",   32'(obs_tx),   32'd1);
    check("mid_rst_busy", 32'(obs_busy), 32'd0);
    check("mid_rst_done", 32'(obs_done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_after_done", 32'(obs_done), 32'd0);
      check("mid_after_tx",   32'(obs_tx),   32'd1);
    end
    start(8'hFF);
    watch("ff4", 10'b1111111110, 1'b0);
    post("ff4");

    // Two clocks per bit: 20-cycle frames.
    sel = 1'b1;
    @(negedge clk);
    check("c2_idle_tx",   32'(obs_tx),   32'd1);
    check("c2_idle_busy", 32'(obs_busy), 32'd0);
    start(8'h00);
    watch("c2_00", 10'b1000000000, 1'b0);
    post("c2_00");
    start(8'hFF);
    watch("c2_ff", 10'b1111111110, 1'b0);
    post("c2_ff");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
